// File: rtl/dmem_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_if
//  Description : Request/acknowledge bus between the M-stage data-memory port
//                (master) and an external variable-latency data memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_port_if;

    logic        mem_req;    // request held high for the whole transaction
    logic        mem_we;     // 1 = write, 0 = read; valid while mem_req
    logic [31:0] mem_addr;   // word-aligned byte address; valid while mem_req
    logic [31:0] mem_wdata;  // store data; valid while mem_req
    logic        mem_ack;    // one-cycle completion strobe from memory
    logic [31:0] mem_rdata;  // read data, valid in the mem_ack cycle

    // Port side: drives the request, consumes the acknowledge.
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    // Memory side: consumes the request, drives the acknowledge.
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface : dmem_port_if
`default_nettype wire

// File: rtl/dmem_port.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port
//  Description : Memory-stage data-memory port of the 5-stage pipeline.
//                Turns an M-stage load/store into one req/ack transaction on
//                an external variable-latency memory, stalls the pipeline
//                while it is outstanding, and returns load data to the M/W
//                register. Misaligned accesses are rejected with a pulse;
//                transactions that never see an ack are aborted after
//                TIMEOUT cycles with a sticky error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_port #(
    parameter int unsigned TIMEOUT = 16,           // 2..255 BUSY cycles
    parameter logic [31:0] ERRDATA = 32'hDEADBEEF  // load result on timeout
) (
    input  logic        clk,
    input  logic        reset,        // synchronous, active low

    // M-stage access
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,

    // Results / pipeline control
    output logic [31:0] readdataM,
    output logic        memstall,
    output logic        misaligned,
    output logic        timeout_err,

    // External memory bus
    dmem_port_if.master mem
);

    // Last BUSY cycle index before the transaction is abandoned.
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for an M-stage access
        S_BUSY = 2'd1,   // request outstanding on the memory bus
        S_DONE = 2'd2    // one un-stalled cycle so the pipeline advances
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [31:0] readdata_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        misaligned_q;
    logic        timeout_err_q;

    logic        w_access;
    logic        w_aligned;
    logic        w_last;

    // A simultaneous read and write strobe is serviced as a write, because
    // mem_we is taken straight from memwriteM.
    assign w_access  = memreadM | memwriteM;
    assign w_aligned = (aluoutM[1:0] == 2'b00);
    assign w_last    = (cnt_q == c_CNT_LAST);
    assign cnt_d     = cnt_q + 8'd1;

    // Stall must be raised in the detect cycle itself, before the request is
    // registered, so the access instruction cannot slip out of M.
    assign memstall = (state_q == S_BUSY) ||
                      ((state_q == S_IDLE) && w_access && w_aligned);

    // Transaction FSM with all bus and result outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            readdata_q    <= 32'd0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            misaligned_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // misaligned is a single-cycle pulse unless re-armed below
            misaligned_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // mem_ack is deliberately not looked at here: a stray
                    // strobe with no request outstanding is meaningless.
                    if (w_access) begin
                        if (w_aligned) begin
                            addr_q  <= aluoutM;
                            wdata_q <= writedataM;
                            we_q    <= memwriteM;
                            req_q   <= 1'b1;
                            cnt_q   <= 8'd0;
                            state_q <= S_BUSY;
                        end else begin
                            misaligned_q <= 1'b1;
                        end
                    end
                end

                S_BUSY: begin
                    cnt_q <= cnt_d;
                    // An ack in the final allowed cycle still counts as a
                    // normal completion, so it is checked first.
                    if (mem.mem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            readdata_q <= mem.mem_rdata;
                        end
                        state_q <= S_DONE;
                    end else if (w_last) begin
                        req_q         <= 1'b0;
                        timeout_err_q <= 1'b1;
                        if (!we_q) begin
                            readdata_q <= ERRDATA;
                        end
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    // M-stage strobes still show the completed instruction
                    // here, so they are ignored for this one cycle.
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign readdataM     = readdata_q;
    assign misaligned    = misaligned_q;
    assign timeout_err   = timeout_err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule : dmem_port
`default_nettype wire

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Memory-stage data-memory port for the 5-stage pipelined processor.
- Consumes the M-stage access (ALU address, store data, read/write strobes) and runs a req/ack transaction to an external variable-latency data memory.
- Returns readdataM to the M/W pipeline register.
- Raises memstall to freeze the whole pipeline until the access completes.

Parameters:
TIMEOUT, 16, max cycles in BUSY without mem_ack before abort (2..255)
ERRDATA, 32'hDEADBEEF, value loaded into readdataM when a read times out

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
memreadM  input  1  load in M stage
memwriteM  input  1  store in M stage
aluoutM  input  32  byte address of access
writedataM  input  32  store data
readdataM  output  32  load result to W pipeline register
memstall  output  1  hold all pipeline registers this cycle
misaligned  output  1  one-cycle pulse: access rejected, addr[1:0] != 0
timeout_err  output  1  sticky: a transaction timed out
mem_req  output  1  request to external memory
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  32  word-aligned address; valid while mem_req
mem_wdata  output  32  write data; valid while mem_req
mem_ack  input  1  one-cycle completion strobe from memory
mem_rdata  input  32  read data, valid in mem_ack cycle

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE; counter=0.
  - readdataM=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, misaligned=0, timeout_err=0.
  - Reset mid-transaction: mem_req drops after that edge; any later mem_ack is ignored.
- access = memreadM | memwriteM; both asserted is treated as a write.
- States: IDLE, BUSY, DONE.
- IDLE, access with aluoutM[1:0]==0:
  - memstall=1 combinationally in the same cycle.
  - At the edge: capture mem_addr=aluoutM, mem_wdata=writedataM, mem_we=memwriteM; mem_req<=1; counter<=0; go BUSY.
- IDLE, access with aluoutM[1:0]!=0:
  - No transaction; memstall=0; misaligned=1 for the next cycle only; readdataM unchanged; stay IDLE.
- IDLE, no access: memstall=0. mem_ack received in IDLE is ignored.
- BUSY:
  - memstall=1; mem_req held high, mem_we/mem_addr/mem_wdata held stable; counter increments each cycle.
  - On mem_ack: mem_req<=0; if read, readdataM<=mem_rdata; go DONE.
  - If counter==TIMEOUT-1 with no ack: mem_req<=0; timeout_err<=1; if read, readdataM<=ERRDATA; go DONE.
  - An ack arriving in that same cycle wins (normal completion, no error).
- DONE:
  - memstall=0 for exactly one cycle, so the pipeline advances the completed instruction; memreadM/memwriteM are ignored this cycle.
  - Go IDLE unconditionally.
  - Back-to-back M-stage accesses therefore cost at least 3 cycles each (IDLE detect, >=1 BUSY, DONE).
- Latency from mem_ack to readdataM valid: 1 edge. readdataM holds until the next read completes; writes never change it.
- timeout_err clears only on reset.
- memstall is the only combinational output; it depends on state, memreadM, memwriteM and aluoutM[1:0]. All other outputs are registered.

Test Plan:
- Aligned load: memreadM=1, aluoutM=0x100, memory acks 3 cycles after req with mem_rdata=0x12345678 -> mem_req high 3 cycles, mem_addr=0x100, mem_we=0; memstall high from the detect cycle through the ack cycle; readdataM=0x12345678 in DONE; memstall=0 in DONE.
- Aligned store: memwriteM=1, aluoutM=0x204, writedataM=0xCAFEF00D, ack after 1 cycle -> mem_we=1, mem_wdata=0xCAFEF00D stable while req; readdataM unchanged.
- Misaligned load: aluoutM=0x103 -> no mem_req, memstall=0, misaligned=1 for one cycle, state stays IDLE.
- Timeout (TIMEOUT=16, read, no ack) -> mem_req drops after 16 BUSY cycles; timeout_err=1 and stays set; readdataM=0xDEADBEEF; ack on cycle 16 instead -> normal completion, no error.
- Reset mid-BUSY: reset=0 for one edge -> mem_req=0, memstall=0, readdataM=0, timeout_err=0; a stale mem_ack afterwards is ignored.
- Back-to-back: load then store held in M with 0-cycle-delay acks -> each access shows IDLE/BUSY/DONE sequence; second request issued only after DONE; both/read+write asserted together -> mem_we=1.
